// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch unit: control-flow ops and run-state FSM states.
package fetch_pkg;

    typedef enum logic [1:0] {
        OP_SEQ    = 2'b00,
        OP_BRANCH = 2'b01,
        OP_CALL   = 2'b10,
        OP_RET    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

endpackage

// File: rtl/fetch_unit_v2_return_stack.sv
// Circular return-address stack: pushing onto a full stack silently replaces the oldest entry.
module return_stack #(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] pop_data,
    output logic            full,
    output logic            empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top;
    logic [CNT_W-1:0] count;

    // top names the next free slot; when full that slot is the oldest entry
    assign pop_data = mem[top - PTR_W'(1)];
    assign full     = (count == CNT_W'(RAS_DEPTH));
    assign empty    = (count == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            top   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            mem[top] <= push_data;
            top      <= top + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_unit_v2.sv
// Fetch unit: run/halt FSM, program counter with next-pc mux, return-address stack and sticky stack error flags.
module fetch_unit_v2
    import fetch_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int INSTR_W   = 9,
    parameter int OFF_W     = 5,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [PC_W-1:0]    start_address,
    input  logic               halt,
    input  logic               stall,
    input  logic [1:0]         op,
    input  logic               taken,
    input  logic [OFF_W-1:0]   offset,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    pc,
    output logic               valid,
    output logic               halted,
    output logic               ras_overflow,
    output logic               ras_underflow,
    output state_t             state_dbg
);

    state_t           state;
    op_t              op_q;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  pc_rel;
    logic             advance;
    logic             ras_push;
    logic             ras_pop;
    logic [PC_W-1:0]  ras_top;
    logic             ras_full;
    logic             ras_empty;

    assign op_q    = op_t'(op);
    assign off_ext = PC_W'($signed(offset));
    assign pc_inc  = pc + PC_W'(1);
    assign pc_rel  = pc + off_ext;

    // A RUN cycle that actually consumes op: not overridden by start, halt or stall
    assign advance  = (state == ST_RUN) && !start && !halt && !stall;
    assign ras_push = advance && (op_q == OP_CALL);
    assign ras_pop  = advance && (op_q == OP_RET);

    // valid qualifies instruction as a real fetch; there is no ready, memory reads are combinational
    assign valid       = (state == ST_RUN);
    assign halted      = (state == ST_HALTED);
    assign imem_addr   = pc;
    assign instruction = valid ? imem_data : '0;
    assign state_dbg   = state;

    return_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .clear     (start),
        .push_data (pc_inc),
        .pop_data  (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            pc            <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else if (start) begin
            state         <= ST_RUN;
            pc            <= start_address;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (halt) begin
                        state <= ST_HALTED;
                    end else if (!stall) begin
                        case (op_q)
                            OP_SEQ:    pc <= pc_inc;
                            OP_BRANCH: pc <= taken ? pc_rel : pc_inc;
                            OP_CALL: begin
                                pc <= pc_rel;
                                if (ras_full) ras_overflow <= 1'b1;
                            end
                            OP_RET: begin
                                if (ras_empty) begin
                                    pc            <= pc_inc;
                                    ras_underflow <= 1'b1;
                                end else begin
                                    pc <= ras_top;
                                end
                            end
                            default: pc <= pc_inc;
                        endcase
                    end
                end
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit_v2.sv
// Directed plus random checks of fetch_unit_v2 against a queue-based reference model.
module tb_fetch_unit_v2;
    import fetch_pkg::*;

    localparam int PC_W      = 8;
    localparam int INSTR_W   = 9;
    localparam int OFF_W     = 5;
    localparam int RAS_DEPTH = 4;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [PC_W-1:0]    start_address;
    logic               halt;
    logic               stall;
    logic [1:0]         op;
    logic               taken;
    logic [OFF_W-1:0]   offset;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [INSTR_W-1:0] instruction;
    logic [PC_W-1:0]    pc;
    logic               valid;
    logic               halted;
    logic               ras_overflow;
    logic               ras_underflow;
    state_t             state_dbg;

    int tests = 0;
    int fails = 0;

    // reference model state
    int              m_state;
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] m_ras[$];
    bit              m_ovf;
    bit              m_unf;

    fetch_unit_v2 #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .start_address (start_address),
        .halt          (halt),
        .stall         (stall),
        .op            (op),
        .taken         (taken),
        .offset        (offset),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instruction   (instruction),
        .pc            (pc),
        .valid         (valid),
        .halted        (halted),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow),
        .state_dbg     (state_dbg)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [PC_W-1:0] sx(input logic [OFF_W-1:0] o);
        int v;
        v = o[OFF_W-1] ? int'(o) - (1 << OFF_W) : int'(o);
        return PC_W'(v);
    endfunction

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = '0;
        m_ras.delete();
        m_ovf   = 0;
        m_unf   = 0;
    endtask

    task automatic model_step(input bit st, input logic [PC_W-1:0] sa, input bit h,
                              input bit sl, input logic [1:0] o, input bit tk,
                              input logic [OFF_W-1:0] off);
        if (st) begin
            m_state = M_RUN;
            m_pc    = sa;
            m_ras.delete();
            m_ovf   = 0;
            m_unf   = 0;
        end else if (m_state == M_RUN) begin
            if (h) begin
                m_state = M_HALT;
            end else if (!sl) begin
                case (o)
                    2'd0: m_pc = m_pc + 8'd1;
                    2'd1: m_pc = tk ? m_pc + sx(off) : m_pc + 8'd1;
                    2'd2: begin
                        m_ras.push_back(m_pc + 8'd1);
                        if (m_ras.size() > RAS_DEPTH) begin
                            void'(m_ras.pop_front());
                            m_ovf = 1;
                        end
                        m_pc = m_pc + sx(off);
                    end
                    default: begin
                        if (m_ras.size() == 0) begin
                            m_unf = 1;
                            m_pc  = m_pc + 8'd1;
                        end else begin
                            m_pc = m_ras.pop_back();
                        end
                    end
                endcase
            end
        end
    endtask

    // scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},        32'(pc),            32'(m_pc));
        chk({tag, ".imem_addr"}, 32'(imem_addr),     32'(m_pc));
        chk({tag, ".valid"},     32'(valid),         32'(m_state == M_RUN));
        chk({tag, ".halted"},    32'(halted),        32'(m_state == M_HALT));
        chk({tag, ".instr"},     32'(instruction),   (m_state == M_RUN) ? 32'(imem_data) : 32'd0);
        chk({tag, ".ovf"},       32'(ras_overflow),  32'(m_ovf));
        chk({tag, ".unf"},       32'(ras_underflow), 32'(m_unf));
    endtask

    // driver: apply inputs, advance model, clock, compare #1 after the edge
    task automatic step(input string tag, input bit st = 0, input logic [PC_W-1:0] sa = '0,
                        input bit h = 0, input bit sl = 0, input logic [1:0] o = 2'd0,
                        input bit tk = 0, input logic [OFF_W-1:0] off = '0);
        start         = st;
        start_address = sa;
        halt          = h;
        stall         = sl;
        op            = o;
        taken         = tk;
        offset        = off;
        model_step(st, sa, h, sl, o, tk, off);
        @(posedge clock);
        #1;
        imem_data = INSTR_W'($urandom);
        #1;
        check_all(tag);
    endtask

    initial begin
        start = 0; start_address = '0; halt = 0; stall = 0;
        op = 2'd0; taken = 0; offset = '0; imem_data = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        imem_data = 9'h1A5;
        #1;
        check_all("reset");
        chk("reset.state", 32'(state_dbg), 32'(ST_IDLE));
        reset_n = 1'b1;

        // IDLE ignores op and halt
        step("idle_seq", 0, '0, 0, 0, 2'd0);
        step("idle_halt", 0, '0, 1, 0, 2'd2, 0, 5'd3);

        // start then sequential fetch
        step("start10", 1, 8'h10);
        chk("start10.pc_const", 32'(pc), 32'h10);
        chk("start10.valid_const", 32'(valid), 32'd1);
        step("seq1", 0, '0, 0, 0, 2'd0);
        step("seq2", 0, '0, 0, 0, 2'd0);
        step("seq3", 0, '0, 0, 0, 2'd0);
        chk("seq3.pc_const", 32'(pc), 32'h13);

        // branches and wrap
        step("start20a", 1, 8'h20);
        step("br_taken", 0, '0, 0, 0, 2'd1, 1, 5'h1C);
        chk("br_taken.pc_const", 32'(pc), 32'h1C);
        step("start20b", 1, 8'h20);
        step("br_not", 0, '0, 0, 0, 2'd1, 0, 5'h1C);
        chk("br_not.pc_const", 32'(pc), 32'h21);
        step("startFF", 1, 8'hFF);
        step("wrap", 0, '0, 0, 0, 2'd0);
        chk("wrap.pc_const", 32'(pc), 32'h00);
        step("start01", 1, 8'h01);
        step("neg_wrap", 0, '0, 0, 0, 2'd1, 1, 5'h1D);
        chk("neg_wrap.pc_const", 32'(pc), 32'hFE);

        // nested calls
        step("start30", 1, 8'h30);
        step("call5", 0, '0, 0, 0, 2'd2, 0, 5'd5);
        chk("call5.pc_const", 32'(pc), 32'h35);
        step("call2", 0, '0, 0, 0, 2'd2, 0, 5'd2);
        chk("call2.pc_const", 32'(pc), 32'h37);
        step("ret1", 0, '0, 0, 0, 2'd3);
        chk("ret1.pc_const", 32'(pc), 32'h36);
        step("ret2", 0, '0, 0, 0, 2'd3);
        chk("ret2.pc_const", 32'(pc), 32'h31);
        chk("ret2.unf_const", 32'(ras_underflow), 32'd0);

        // overflow then underflow
        step("start50", 1, 8'h50);
        for (int i = 0; i < 5; i++) step("ovf_call", 0, '0, 0, 0, 2'd2, 0, 5'd1);
        chk("ovf.flag_const", 32'(ras_overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step("ovf_ret", 0, '0, 0, 0, 2'd3);
            chk("ovf_ret.pc_const", 32'(pc), 32'(8'h55 - 8'(i)));
        end
        step("unf_ret", 0, '0, 0, 0, 2'd3);
        chk("unf_ret.pc_const", 32'(pc), 32'h53);
        chk("unf_ret.flag_const", 32'(ras_underflow), 32'd1);
        step("flags_clr", 1, 8'h00);
        chk("flags_clr.ovf", 32'(ras_overflow), 32'd0);

        // stall, halt, restart
        step("start60", 1, 8'h60);
        step("call4", 0, '0, 0, 0, 2'd2, 0, 5'd4);
        for (int i = 0; i < 3; i++) step("stall_call", 0, '0, 0, 1, 2'd2, 0, 5'd4);
        chk("stall.pc_const", 32'(pc), 32'h64);
        step("ret_after_stall", 0, '0, 0, 0, 2'd3);
        chk("ret_after_stall.pc_const", 32'(pc), 32'h61);
        step("halt", 0, '0, 1, 0, 2'd0);
        chk("halt.halted_const", 32'(halted), 32'd1);
        chk("halt.instr_const", 32'(instruction), 32'd0);
        step("halt_seq", 0, '0, 0, 0, 2'd0);
        step("halt_call", 0, '0, 0, 0, 2'd2, 0, 5'd7);
        chk("halt.pc_const", 32'(pc), 32'h61);
        step("restart", 1, 8'h70);

        // asynchronous reset between edges
        step("start43", 1, 8'h43);
        step("unf44", 0, '0, 0, 0, 2'd3);
        chk("unf44.pc_const", 32'(pc), 32'h44);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("async_rst.state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 19) == 0) || (i == 0),
                 PC_W'($urandom),
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 5) == 0,
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 OFF_W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit_v2.md
Name: fetch_unit_v2

Overview:
- Parametrised next-generation fetch unit: owns the program counter, computes the next fetch address, and drives an external instruction memory.
- Adds over the first design:
  - async active-low reset;
  - run/halt state machine;
  - pipeline stall;
  - call/return through a hardware return-address stack (RAS);
  - configurable PC/offset/instruction widths;
  - a fetch-valid qualifier and sticky stack error flags.
- Sits between the controller (start/halt, decoded control-flow op) and instruction memory.

Parameters:
PC_W, 8, program counter / instruction address width
INSTR_W, 9, instruction word width
OFF_W, 5, signed relative offset width (OFF_W <= PC_W)
RAS_DEPTH, 4, return-address stack entries (power of two, >= 2)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  load start_address, enter RUN, clear RAS and error flags
start_address  in  PC_W  program entry point
halt  in  1  enter HALTED (ignored while start=1)
stall  in  1  hold PC and RAS this cycle
op  in  2  control-flow op: 00 SEQ, 01 BRANCH, 10 CALL, 11 RET
taken  in  1  branch condition, used only when op=BRANCH
offset  in  OFF_W  signed relative target for BRANCH and CALL
imem_addr  out  PC_W  instruction memory address (= pc)
imem_data  in  INSTR_W  instruction memory read data (combinational read)
instruction  out  INSTR_W  imem_data when valid, else 0
pc  out  PC_W  current program counter
valid  out  1  high in RUN: instruction is a real fetch
halted  out  1  high in HALTED
ras_overflow  out  1  sticky: CALL pushed onto a full RAS
ras_underflow  out  1  sticky: RET popped an empty RAS

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, pc=0, RAS empty (count=0);
  - ras_overflow=0, ras_underflow=0, valid=0, halted=0, instruction=0.
- States: IDLE, RUN, HALTED.
  - valid=1 only in RUN; halted=1 only in HALTED.
  - In IDLE and HALTED, pc holds and op/stall are ignored.
- Per-cycle priority:
  1. start: from any state -> RUN, pc<=start_address, RAS cleared, flags cleared.
  2. halt (RUN only): -> HALTED, pc holds; op is ignored.
  3. stall (RUN): pc, RAS, state hold.
  4. op (RUN):
     - SEQ: pc+1.
     - BRANCH: taken=1 -> pc+sext(offset); taken=0 -> pc+1.
     - CALL: push pc+1; pc <= pc+sext(offset).
     - RET: pop; pc <= popped value.
- Only start leaves HALTED; halt has no effect in IDLE.
- Arithmetic:
  - all sums are modulo 2^PC_W;
  - pc=2^PC_W-1 with SEQ wraps to 0;
  - negative offsets wrap below 0 (pc=1, offset=-3 -> 2^PC_W-2);
  - offset is sign-extended to PC_W before the add.
- RAS: circular buffer (top pointer plus count saturating at RAS_DEPTH).
  - CALL when full: oldest entry overwritten, count stays RAS_DEPTH, ras_overflow<=1.
  - RET when empty: pc <= pc+1, count stays 0, ras_underflow<=1.
- Latency:
  - a new pc is visible one clock after the controlling inputs are sampled;
  - imem_addr equals pc combinationally;
  - instruction follows imem_data combinationally.
- Reset mid-operation: all state cleared immediately, regardless of clock.

Decomposition:
- fetch_pkg holds:
  - the op encoding enum (OP_SEQ, OP_BRANCH, OP_CALL, OP_RET);
  - the state enum (ST_IDLE, ST_RUN, ST_HALTED).
- One sub-module, return_stack:
  - parametrised by PC_W and RAS_DEPTH;
  - ports: push, pop, clear, push_data, pop_data, full, empty;
  - instantiated once.
- The top holds the FSM, next-pc mux and sticky flags.

Test Plan:
- Reset, then start=1 with start_address=0x10, then 3 SEQ cycles -> pc 0x10,0x11,0x12,0x13; valid=1 from the cycle after start.
- pc=0x20, BRANCH taken with offset=-4 -> pc=0x1C; same op with taken=0 -> pc=0x21; pc=0xFF SEQ -> pc=0x00.
- Nested CALLs:
  - pc=0x30 CALL +5 -> 0x35;
  - at 0x35 CALL +2 -> 0x37;
  - RET -> 0x36; RET -> 0x31;
  - ras_underflow stays 0.
- RAS edges:
  - 5 CALLs with RAS_DEPTH=4 -> ras_overflow=1; 4 RETs return the newest 4 addresses in order.
  - 5th RET -> pc+1, ras_underflow=1.
  - A subsequent start clears both flags.
- stall=1 for 3 cycles with op=CALL -> pc and RAS unchanged. Then halt -> halted=1, valid=0, instruction=0, pc frozen. start leaves HALTED.
- Assert reset_n=0 between clock edges while in RUN at pc=0x44 -> pc=0, state IDLE, flags 0 immediately, before the next edge.
